// File: rtl/video_sig_capture_pkg.sv
// Purpose : shared constants, line-record layout and the CRC-32/MPEG-2 fold for the signature tap.
// Latency : n/a (package).
// Backpressure: n/a (package).
package video_sig_capture_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

    // Widest pixel the fold accepts in one call.
    localparam int CRC_DATA_MAX = 64;

    // Widest counter a line record can carry. Instances build their own
    // record type at their CNT_W; this layout is the FIFO's default.
    localparam int REC_CNT_MAX = 16;

    typedef struct packed {
        logic [REC_CNT_MAX-1:0] idx;
        logic [REC_CNT_MAX-1:0] len;
        logic [31:0]            crc;
    } line_rec_t;

    // Folds the low 'width' bits of data into crc, MSB first, no reflection.
    // The data is left-aligned first so the loop only ever looks at the top bit.
    function automatic logic [31:0] crc32_fold(input logic [31:0]             crc,
                                               input logic [CRC_DATA_MAX-1:0] data,
                                               input int                      width);
        logic [31:0]             c;
        logic [CRC_DATA_MAX-1:0] d;
        logic                    fb;
        c  = crc;
        d  = data << (CRC_DATA_MAX - width);
        fb = 1'b0;
        for (int k = 0; k < CRC_DATA_MAX; k++) begin
            if (k < width) begin
                fb = c[31] ^ d[CRC_DATA_MAX-1];
                c  = {c[30:0], 1'b0} ^ (fb ? CRC32_POLY : 32'h0);
                d  = d << 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/video_sig_capture_if.sv
// Purpose : bundles the tapped video stream and the line-record valid/ready output.
// Latency : n/a (wiring only).
// Backpressure: line_ready from the consumer; the video side has none (passive tap).
// Ports   : ce/de/vs/rgb video in, line_valid/line_ready handshake, line_idx/len/crc record.
interface video_sig_capture_if #(
    parameter int PIX_W = 24,
    parameter int CNT_W = 10
);
    logic             ce;
    logic             de;
    logic             vs;
    logic [PIX_W-1:0] rgb;
    logic             line_valid;
    logic             line_ready;
    logic [CNT_W-1:0] line_idx;
    logic [CNT_W-1:0] line_len;
    logic [31:0]      line_crc;

    // master: stream source / record consumer (bench or host).
    modport master (
        output ce, de, vs, rgb, line_ready,
        input  line_valid, line_idx, line_len, line_crc
    );

    // slave: the capture block.
    modport slave (
        input  ce, de, vs, rgb, line_ready,
        output line_valid, line_idx, line_len, line_crc
    );
endinterface

// File: rtl/video_sig_capture_sig_rec_fifo.sv
// Purpose : synchronous FIFO of line records with registered head (valid + data flops).
// Latency : a pushed record shows at the head one clk after the push, never bypassed.
// Backpressure: push when full is accepted only with a same-cycle pop, else dropped (drop=1).
// Ports   : clk/rst, clr (flush, beats push), push_vld/push_dat, pop_vld/pop_rdy/pop_dat, drop.
module sig_rec_fifo
    import video_sig_capture_pkg::*;
#(
    parameter type rec_t = line_rec_t,
    parameter int  DEPTH = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic push_vld,
    input  rec_t push_dat,
    output logic pop_vld,
    input  logic pop_rdy,
    output rec_t pop_dat,
    output logic drop
);
    localparam int AW = $clog2(DEPTH);

    rec_t          mem [DEPTH];
    logic [AW-1:0] wptr, rptr, rptr_nx;
    logic [AW:0]   cnt, cnt_nx;
    logic          pop, wr, full;

    assign pop  = pop_vld & pop_rdy;
    assign full = (cnt == (AW+1)'(DEPTH));
    assign wr   = push_vld & ~clr & (~full | pop);
    assign drop = push_vld & ~clr & full & ~pop;

    always_comb begin
        rptr_nx = pop ? rptr + AW'(1) : rptr;
        cnt_nx  = cnt;
        if (wr && !pop)
            cnt_nx = cnt + (AW+1)'(1);
        else if (!wr && pop)
            cnt_nx = cnt - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (wr)
            mem[wptr] <= push_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            pop_vld <= 1'b0;
            pop_dat <= '0;
        end else if (clr) begin
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            pop_vld <= 1'b0;
            pop_dat <= '0;
        end else begin
            if (wr)
                wptr <= wptr + AW'(1);
            rptr    <= rptr_nx;
            cnt     <= cnt_nx;
            pop_vld <= (cnt_nx != '0);
            // The slot being written is the new head only when the FIFO is
            // otherwise empty after this cycle; mem has not got it yet.
            pop_dat <= (wr && (wptr == rptr_nx)) ? push_dat : mem[rptr_nx];
        end
    end
endmodule

// File: rtl/video_sig_capture.sv
// Purpose : passive tap computing per-line and per-frame CRC-32/MPEG-2 over active pixels.
// Latency : line record at FIFO head 1 clk after its line end; frame_done 1 clk after VS rise.
// Backpressure: none on video; records dropped (sticky overflow) when the FIFO is full.
// Ports   : clk/rst, vif (video in + record out), en (arm at VS rise), clr,
//           frame_done/frame_lines/frame_crc, overflow.
module video_sig_capture
    import video_sig_capture_pkg::*;
#(
    parameter int PIX_W = 24,
    parameter int CNT_W = 10,
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    video_sig_capture_if.slave   vif,
    input  logic                 en,
    input  logic                 clr,
    output logic                 frame_done,
    output logic [CNT_W-1:0]     frame_lines,
    output logic [31:0]          frame_crc,
    output logic                 overflow
);
    typedef struct packed {
        logic [CNT_W-1:0] idx;
        logic [CNT_W-1:0] len;
        logic [31:0]      crc;
    } cap_rec_t;

    logic             de_q, vs_q, armed, in_line;
    logic [31:0]      line_crc, frame_acc;
    logic [CNT_W-1:0] len, idx;

    logic             start, pix, lend_fall, fend, push, in_line_nx, drop;
    logic [31:0]      crc_base, line_crc_nx, frame_acc_nx;
    logic [CNT_W-1:0] len_nx, idx_after;
    cap_rec_t         push_rec, head_rec;
    logic             head_vld;

    assign start = vif.ce & armed & vif.de & ~de_q;
    // in_line keeps a force-ended DE period from being counted as pixels
    // until DE falls and rises again.
    assign pix       = vif.ce & armed & vif.de & (in_line | ~de_q);
    assign lend_fall = vif.ce & armed & in_line & de_q & ~vif.de;
    assign fend      = vif.ce & vif.vs & ~vs_q;
    // A VS rise during a pixel closes the line including that pixel.
    assign push       = lend_fall | (fend & pix);
    assign in_line_nx = push ? 1'b0 : (pix ? 1'b1 : in_line);

    assign crc_base     = start ? CRC32_INIT : line_crc;
    assign line_crc_nx  = pix ? crc32_fold(crc_base, CRC_DATA_MAX'(vif.rgb), PIX_W) : line_crc;
    assign frame_acc_nx = pix ? crc32_fold(frame_acc, CRC_DATA_MAX'(vif.rgb), PIX_W) : frame_acc;

    assign len_nx    = start ? CNT_W'(1)
                     : (pix && (len != '1)) ? len + CNT_W'(1) : len;
    // Line index after any push this cycle; this is what a same-cycle
    // frame end reports, so the closing line is counted.
    assign idx_after = (push && (idx != '1)) ? idx + CNT_W'(1) : idx;

    assign push_rec = '{idx: idx, len: len_nx, crc: line_crc_nx};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_q        <= 1'b0;
            vs_q        <= 1'b0;
            armed       <= 1'b0;
            in_line     <= 1'b0;
            line_crc    <= CRC32_INIT;
            frame_acc   <= CRC32_INIT;
            len         <= '0;
            idx         <= '0;
            frame_done  <= 1'b0;
            frame_lines <= '0;
            frame_crc   <= '0;
            overflow    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (vif.ce) begin
                de_q <= vif.de;
                vs_q <= vif.vs;
            end
            line_crc <= line_crc_nx;
            len      <= len_nx;
            in_line  <= in_line_nx;
            if (fend) begin
                if (armed && (idx_after != '0)) begin
                    frame_done  <= 1'b1;
                    frame_lines <= idx_after;
                    frame_crc   <= frame_acc_nx;
                end
                idx       <= '0;
                frame_acc <= CRC32_INIT;
                armed     <= en;
            end else begin
                idx       <= idx_after;
                frame_acc <= frame_acc_nx;
            end
            if (clr)
                overflow <= 1'b0;
            else if (drop)
                overflow <= 1'b1;
        end
    end

    sig_rec_fifo #(
        .rec_t (cap_rec_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .push_vld (push),
        .push_dat (push_rec),
        .pop_vld  (head_vld),
        .pop_rdy  (vif.line_ready),
        .pop_dat  (head_rec),
        .drop     (drop)
    );

    assign vif.line_valid = head_vld;
    assign vif.line_idx   = head_rec.idx;
    assign vif.line_len   = head_rec.len;
    assign vif.line_crc   = head_rec.crc;
endmodule

// File: doc/video_sig_capture.md
Name: video_sig_capture

Overview:
- Passive tap on the TV-1 video output stream (CE, DE, VS, RGB). Computes a per-line and per-frame CRC-32 over active pixels and buffers per-line records for a host or testbench.
- Gives automated pass/fail render regression in sim and on-FPGA, replacing text pixel dumps.
- Generalised in pixel width, counter width and record depth.

Parameters:
PIX_W, 24, bits per pixel fed into the CRC each pixel (MSB first)
CNT_W, 10, width of the pixel-per-line and line-per-frame counters
DEPTH, 16, line-record FIFO depth (power of two, >=2)

Ports:
CLK  in  1  system clock
RST  in  1  reset, asynchronous, active-high
CE  in  1  pixel clock enable; DE, VS and RGB are sampled only when CE=1
DE  in  1  active display
VS  in  1  vertical sync
RGB  in  PIX_W  pixel data
EN  in  1  capture enable, sampled at VS rising edge
CLR  in  1  synchronous clear of OVERFLOW and the FIFO
LINE_VALID  out  1  FIFO head record valid
LINE_READY  in  1  consumer pops the head when LINE_VALID & LINE_READY
LINE_IDX  out  CNT_W  line index within the frame
LINE_LEN  out  CNT_W  pixel count of the line
LINE_CRC  out  32  CRC of the line
FRAME_DONE  out  1  one-CLK pulse at frame end
FRAME_LINES  out  CNT_W  lines in the completed frame
FRAME_CRC  out  32  CRC of all pixels of the completed frame
OVERFLOW  out  1  sticky; set when a record is dropped

Behaviour:
- Reset values:
  - All outputs 0.
  - FIFO empty; counters 0; CRC registers 0xFFFFFFFF.
  - Armed=0, so no capture until the first VS rise with EN=1.
- CRC algorithm: CRC-32/MPEG-2.
  - Poly 0x04C11DB7, init 0xFFFFFFFF, no reflection, no final XOR.
  - All PIX_W bits of a pixel are folded in one CLK, MSB first.
- Edge detection: registered DE_q and VS_q, updated only on CE cycles.
- Line start: CE & DE & ~DE_q, while armed.
  - Line CRC is reset to init, then the first pixel is folded in the same cycle.
  - LEN is set to 1.
- Pixel: CE & DE while armed.
  - Line CRC and frame CRC are both updated.
  - LEN increments, saturating at 2^CNT_W-1 (CRC still updated after saturation).
- Line end: CE & ~DE & DE_q, while armed.
  - Push {IDX, LEN, CRC} to the FIFO.
  - IDX increments, saturating.
- Frame end: CE & VS & ~VS_q.
  - If armed and IDX>0: FRAME_DONE pulses in the next CLK; FRAME_LINES=IDX and FRAME_CRC=frame CRC are latched and held until the next frame end.
  - In all cases: IDX=0, frame CRC=init, armed=EN.
- Simultaneous events:
  - DE falls on the same CE as VS rises: the line push uses the pre-clear IDX, then the frame end is processed. The line is counted in FRAME_LINES.
  - DE high at the VS rise with no DE fall: the line is forced to end first (push), then the frame end. The remainder of that DE period is ignored until DE next rises.
- FIFO behaviour:
  - LINE_VALID and the record outputs are registered. A record appears on the CLK after its push cycle.
  - Push when full is accepted if a pop occurs in the same cycle. Otherwise the record is dropped and OVERFLOW=1.
  - Push and pop on an empty FIFO: the push is stored (no bypass).
  - Head is stable while LINE_VALID & ~LINE_READY.
- CLR: empties the FIFO and clears OVERFLOW. CLR has priority over a same-cycle push.
- EN deassert mid-frame: takes effect only at the next VS rise. The current frame completes.
- RST mid-line: everything returns to reset values; the partial line is discarded.

Decomposition:
- scv_pkg contains:
  - CRC32_POLY and CRC32_INIT constants.
  - Function crc32_fold(crc, data, width).
  - Typedef line_rec_t {idx, len, crc}, parametrised via CNT_W (localparam struct width).
- One sub-module, sig_rec_fifo: synchronous FIFO of line_rec_t, DEPTH entries, with valid/ready output.
- The edge detection, counters and CRC stay in video_sig_capture.

Test Plan:
- PIX_W=8, EN=1, VS pulse, then a 9-pixel line "123456789" (0x31..0x39), then VS. Expected:
  - Record {IDX=0, LEN=9, CRC=0x0376E6E7}.
  - FRAME_DONE pulse with FRAME_LINES=1 and FRAME_CRC=0x0376E6E7.
- PIX_W=24, 3 identical 256-pixel lines of 0x123456.
  - Three records with IDX 0,1,2, LEN=256 and equal CRCs.
  - FRAME_CRC matches the bench model over 768 pixels.
- DEPTH=4, LINE_READY=0, 6 lines.
  - 4 records retained (IDX 0..3); OVERFLOW=1.
  - Pop with push in the same cycle when full: no drop.
  - CLR: FIFO empty and OVERFLOW=0.
- VS rises while DE is high at pixel 5.
  - Record LEN=5 is pushed before FRAME_DONE.
  - FRAME_LINES includes the line.
  - The next frame starts at IDX=0.
- EN=0 at a VS rise.
  - No records and no FRAME_DONE for that frame.
  - Re-enable: capture resumes at the following VS.
- CNT_W=4, 20-pixel line: LEN=15 (saturated); CRC still covers all 20 pixels.
